// File: rtl/mem_pkg.sv
// mem_pkg: shared constants for the MEM stage.
// Width codes, FSM state encoding, default widths.
package mem_pkg;

    localparam int DEF_NB_DATA = 32;
    localparam int DEF_NB_REG  = 5;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Code 2'b10 falls through to the word rule.
    function automatic logic is_aligned(
        input logic [1:0] width,
        input logic [1:0] lo
    );
        logic ok;
        if (width == W_BYTE)
            ok = 1'b1;
        else if (width == W_HALF)
            ok = ~lo[0];
        else
            ok = (lo == 2'b00);
        return ok;
    endfunction

endpackage

// File: rtl/ls_align.sv
// ls_align: byte-lane steering for stores and loads.
// Purely combinational, little-endian lanes.
module ls_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_lane,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);

    logic        is_b;
    logic        is_h;
    logic [7:0]  b_lane;
    logic [15:0] h_lane;

    assign is_b   = (i_width == W_BYTE);
    assign is_h   = (i_width == W_HALF);
    assign b_lane = i_rdata[{i_lane, 3'b000} +: 8];
    assign h_lane = i_rdata[{i_lane[1], 4'b0000} +: 16];

    // Select enables, replicated store data and extended load data.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        unique case (1'b1)
            is_b: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_sign & b_lane[7]}}, b_lane};
            end
            is_h: begin
                o_be    = 4'b0011 << {i_lane[1], 1'b0};
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{i_sign & h_lane[15]}}, h_lane};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM stage with request/ack data-memory port.
// Optional watchdog: define MEM_ACCESS_TIMEOUT_EN.
module mem_access
    import mem_pkg::*;
#(
    parameter int NB_DATA        = DEF_NB_DATA,
    parameter int NB_REG         = DEF_NB_REG,
    parameter int NB_ADDR        = 10,
    parameter int TIMEOUT_CYCLES = 16
)(
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic               i_mem2reg,
    input  logic               i_memRead,
    input  logic               i_memWrite,
    input  logic               i_regWrite,
    input  logic [1:0]         i_width,
    input  logic               i_sign_flag,
    input  logic [NB_DATA-1:0] i_result,
    input  logic [NB_DATA-1:0] i_data4Mem,
    input  logic [NB_REG-1:0]  i_write_reg,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [NB_ADDR-1:0] o_dmem_addr,
    output logic [NB_DATA-1:0] o_dmem_wdata,
    output logic [3:0]         o_dmem_be,
    input  logic               i_dmem_ack,
    input  logic [NB_DATA-1:0] i_dmem_rdata,
    output logic               o_stall,
    output logic               o_mem2reg,
    output logic               o_regWrite,
    output logic [NB_DATA-1:0] o_read_data,
    output logic [NB_DATA-1:0] o_result,
    output logic [NB_REG-1:0]  o_write_reg,
    output logic               o_misalign,
    output logic               o_bus_err
);

    logic [0:0]         state;
    logic               in_wait;
    logic               mem_op;
    logic               aligned;
    logic               idle_go;
    logic               access;
    logic               misal;
    logic               busy;
    logic               done;
    logic               timeout;

    logic [NB_DATA-1:0] lat_result;
    logic [NB_DATA-1:0] lat_data;
    logic [1:0]         lat_width;
    logic               lat_sign;
    logic               lat_we;
    logic               lat_mem2reg;
    logic               lat_regWrite;
    logic [NB_REG-1:0]  lat_write_reg;

    logic [NB_DATA-1:0] cur_result;
    logic [NB_DATA-1:0] cur_data;
    logic [1:0]         cur_width;
    logic               cur_sign;
    logic               cur_we;
    logic               cur_mem2reg;
    logic               cur_regWrite;
    logic [NB_REG-1:0]  cur_write_reg;

    logic [3:0]         al_be;
    logic [31:0]        al_wdata;
    logic [31:0]        al_rdata;

    assign in_wait = (state == S_WAIT);
    assign mem_op  = i_memRead | i_memWrite;
    assign aligned = is_aligned(i_width, i_result[1:0]);
    assign idle_go = i_reset & ~in_wait & ~i_halt;
    assign access  = idle_go & mem_op & aligned;
    assign misal   = idle_go & mem_op & ~aligned;
    assign busy    = access | in_wait;
    assign done    = busy & i_dmem_ack;

    // Live inputs on the issue cycle, latched copy while waiting.
    always_comb begin
        cur_result    = i_result;
        cur_data      = i_data4Mem;
        cur_width     = i_width;
        cur_sign      = i_sign_flag;
        cur_we        = i_memWrite;
        cur_mem2reg   = i_mem2reg;
        cur_regWrite  = i_regWrite;
        cur_write_reg = i_write_reg;
        if (in_wait) begin
            cur_result    = lat_result;
            cur_data      = lat_data;
            cur_width     = lat_width;
            cur_sign      = lat_sign;
            cur_we        = lat_we;
            cur_mem2reg   = lat_mem2reg;
            cur_regWrite  = lat_regWrite;
            cur_write_reg = lat_write_reg;
        end
    end

    ls_align u_align (
        .i_width (cur_width),
        .i_lane  (cur_result[1:0]),
        .i_sign  (cur_sign),
        .i_wdata (cur_data),
        .i_rdata (i_dmem_rdata),
        .o_be    (al_be),
        .o_wdata (al_wdata),
        .o_rdata (al_rdata)
    );

    assign o_dmem_req   = busy;
    assign o_dmem_we    = busy & cur_we;
    assign o_dmem_addr  = busy ? cur_result[NB_ADDR+1:2] : '0;
    assign o_dmem_be    = busy ? al_be : 4'b0000;
    assign o_dmem_wdata = busy ? al_wdata : '0;
    assign o_stall      = busy & ~i_dmem_ack & ~timeout;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;

    assign timeout = in_wait & ~i_dmem_ack &
                     (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Count unacknowledged WAIT cycles from zero.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            wait_cnt <= '0;
        else if (access & ~i_dmem_ack)
            wait_cnt <= '0;
        else if (in_wait & ~i_dmem_ack)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // One-cycle pulse when the watchdog abandons an access.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            o_bus_err <= 1'b0;
        else
            o_bus_err <= timeout;
    end
`else
    assign timeout   = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // IDLE/WAIT sequencing of the memory handshake.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            state <= S_IDLE;
        else if (access & ~i_dmem_ack)
            state <= S_WAIT;
        else if (in_wait & (i_dmem_ack | timeout))
            state <= S_IDLE;
    end

    // Capture the issuing instruction for the WAIT phase.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            lat_result    <= '0;
            lat_data      <= '0;
            lat_width     <= 2'b00;
            lat_sign      <= 1'b0;
            lat_we        <= 1'b0;
            lat_mem2reg   <= 1'b0;
            lat_regWrite  <= 1'b0;
            lat_write_reg <= '0;
        end else if (access) begin
            lat_result    <= i_result;
            lat_data      <= i_data4Mem;
            lat_width     <= i_width;
            lat_sign      <= i_sign_flag;
            lat_we        <= i_memWrite;
            lat_mem2reg   <= i_mem2reg;
            lat_regWrite  <= i_regWrite;
            lat_write_reg <= i_write_reg;
        end
    end

    // MEM/WB bundle: ack completes, stall/timeout bubble, else pass.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_mem2reg   <= 1'b0;
            o_regWrite  <= 1'b0;
            o_read_data <= '0;
            o_result    <= '0;
            o_write_reg <= '0;
        end else if (done) begin
            o_mem2reg   <= cur_mem2reg;
            o_regWrite  <= cur_regWrite;
            o_read_data <= cur_we ? '0 : al_rdata;
            o_result    <= cur_result;
            o_write_reg <= cur_write_reg;
        end else if (o_stall | timeout) begin
            o_mem2reg   <= 1'b0;
            o_regWrite  <= 1'b0;
            o_read_data <= '0;
        end else if (idle_go) begin
            o_mem2reg   <= misal ? 1'b0 : i_mem2reg;
            o_regWrite  <= misal ? 1'b0 : i_regWrite;
            o_read_data <= '0;
            o_result    <= i_result;
            o_write_reg <= i_write_reg;
        end
    end

    // One-cycle pulse for a rejected misaligned access.
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            o_misalign <= 1'b0;
        else
            o_misalign <= misal;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters SHALL be: NB_DATA, 32, data width; NB_REG, 5, register-index width; NB_ADDR, 10, data-memory word-address width; TIMEOUT_CYCLES, 16, watchdog limit.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-low.
REQ-004 i_halt  in  1  freeze: no new access, write-back outputs hold.
REQ-005 i_mem2reg, i_memRead, i_memWrite, i_regWrite  in  1 each  control from EX/MEM register.
REQ-006 i_width  in  2  00 byte, 01 half, 11 word, 10 treated as word; i_sign_flag  in  1  1 = sign-extend loads.
REQ-007 i_result  in  NB_DATA  ALU result / byte address; i_data4Mem  in  NB_DATA  store data; i_write_reg  in  NB_REG  destination.
REQ-008 o_dmem_req, o_dmem_we  out  1  memory request, write enable; o_dmem_addr  out  NB_ADDR  word address (i_result[NB_ADDR+1:2]).
REQ-009 o_dmem_wdata  out  NB_DATA  lane-replicated store data; o_dmem_be  out  4  byte enables; i_dmem_ack  in  1  completion; i_dmem_rdata  in  NB_DATA  read word.
REQ-010 o_stall  out  1  freeze IF..EX/MEM while access pending.
REQ-011 o_mem2reg, o_regWrite  out  1; o_read_data, o_result  out  NB_DATA; o_write_reg  out  NB_REG  registered MEM/WB bundle.
REQ-012 o_misalign, o_bus_err  out  1  one-cycle registered fault pulses.

Function
REQ-013 FSM states SHALL be IDLE and WAIT; access = (i_memRead|i_memWrite) & aligned & !i_halt in IDLE.
REQ-014 Aligned SHALL mean: byte always; half i_result[0]==0; word i_result[1:0]==00.
REQ-015 On access in IDLE: o_dmem_req=1 combinationally, address/data/be/width/sign/control latched internally; if i_dmem_ack same cycle stay IDLE, else go WAIT.
REQ-016 In WAIT: o_dmem_req held with latched values until i_dmem_ack, then return to IDLE.
REQ-017 o_stall SHALL equal (access in IDLE or state WAIT) & !i_dmem_ack.
REQ-018 Byte enables: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111; wdata byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-019 Load: lane selected by addr[1:0], little-endian, zero- or sign-extended per latched sign flag.
REQ-020 Write-back bundle SHALL register on the ack cycle (memory ops) or each !i_halt cycle (non-memory), latency 1 cycle after ack/entry.
REQ-021 While o_stall=1 the bundle SHALL carry a bubble (o_regWrite=0, o_mem2reg=0).
REQ-022 Misaligned access: no request, o_misalign=1 next cycle, o_regWrite=0 for that instruction.
REQ-023 i_halt SHALL NOT abort a WAIT access; it completes and updates the bundle on ack.
REQ-024 Stores SHALL produce o_regWrite as supplied (normally 0); o_read_data for stores is 0.

Reset
REQ-025 Reset SHALL force IDLE immediately, drop o_dmem_req, and zero every output and internal latch.
REQ-026 Reset mid-WAIT SHALL abandon the access with no write-back and no fault pulse.

Configuration
REQ-027 With MEM_ACCESS_TIMEOUT_EN defined: a counter clears on entering WAIT; reaching TIMEOUT_CYCLES without ack returns to IDLE, pulses o_bus_err, deasserts o_stall, suppresses write-back.
REQ-028 Without MEM_ACCESS_TIMEOUT_EN: WAIT persists indefinitely; o_bus_err tied 0; no counter.

Structure
REQ-029 Package mem_pkg SHALL hold width codes (W_BYTE, W_HALF, W_WORD), FSM state encoding, NB_DATA/NB_REG defaults.
REQ-030 Lane logic (REQ-018/019) SHALL live in combinational sub-module ls_align.

Verification
REQ-031 SB at addr 0x6, data 0x000000A5, ack next cycle -> be 0100, wdata 0xA5A5A5A5, o_stall high 1 cycle, no regWrite.
REQ-032 LH signed at addr 0x2, rdata 0x8001_1234, ack same cycle -> o_stall never high, o_read_data 0xFFFF8001 next cycle.
REQ-033 LW at addr 0x5 -> no o_dmem_req, o_misalign pulse 1 cycle, o_regWrite 0.
REQ-034 LBU addr 0x3, ack after 4 cycles, i_halt asserted during WAIT -> 4 bubble cycles, o_read_data 0x000000xx from byte 3 on completion.
REQ-035 Reset pulse during WAIT -> o_dmem_req low same cycle, all outputs 0, next load proceeds normally.
REQ-036 With MEM_ACCESS_TIMEOUT_EN, no ack for 16 cycles -> o_bus_err pulse, state IDLE, o_stall low, no write-back.
